// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side sequencer,
// plus the execute function used by the reader's ALU.
package instr_register_pkg;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    operand_t rezultat;
  } instruction_t;

  localparam int DEPTH = 32;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT, DONE} reader_state_t;

  typedef struct packed {
    operand_t result;
    logic     div_zero;
  } exec_result_t;

  // Division by zero yields 0 with the flag set rather than an undefined value.
  function automatic exec_result_t exec_op(opcode_t opc, operand_t a, operand_t b);
    exec_result_t r;
    r.result   = '0;
    r.div_zero = 1'b0;
    case (opc)
      ZERO:  r.result = '0;
      PASSA: r.result = a;
      PASSB: r.result = b;
      ADD:   r.result = a + b;
      SUB:   r.result = a - b;
      MULT:  r.result = a * b;
      DIV: begin
        if (b == '0) r.div_zero = 1'b1;
        else         r.result   = a / b;
      end
      MOD: begin
        if (b == '0) r.div_zero = 1'b1;
        else         r.result   = a % b;
      end
      default: r.result = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational execute datapath: applies the opcode to the two operands,
// with the divide-by-zero guard folded in.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output operand_t result,
  output logic     div_zero
);

  exec_result_t res;

  always_comb res = exec_op(opc, op_a, op_b);

  assign result   = res.result;
  assign div_zero = res.div_zero;

endmodule

// File: rtl/instr_reader.sv
// Read-side sequencer: walks read_pointer over a (wrapping) address range,
// executes each instruction and streams one result per entry over valid/ready.
// Optional result self-check enabled by defining INSTR_READER_CHECK_EN.
module instr_reader
  import instr_register_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  address_t     first_addr,
  input  address_t     last_addr,
  input  instruction_t instruction_word,
  output address_t     read_pointer,
  output logic         out_valid,
  input  logic         out_ready,
  output opcode_t      out_opcode,
  output address_t     out_addr,
  output operand_t     out_result,
  output logic         div_zero,
  output logic         busy,
  output logic         done
`ifdef INSTR_READER_CHECK_EN
  ,
  output logic         check_err,
  output logic [5:0]   err_count
`endif
);

  reader_state_t state_q, state_d;
  address_t      read_pointer_q, read_pointer_d;
  address_t      last_addr_q, last_addr_d;
  instruction_t  instr_q, instr_d;
  opcode_t       out_opcode_q, out_opcode_d;
  address_t      out_addr_q, out_addr_d;
  operand_t      out_result_q, out_result_d;
  logic          div_zero_q, div_zero_d;
  operand_t      alu_result;
  logic          alu_div_zero;

`ifdef INSTR_READER_CHECK_EN
  logic       check_err_q, check_err_d;
  logic [5:0] err_count_q, err_count_d;
`else
  logic unused_rezultat;
  assign unused_rezultat = ^instr_q.rezultat;
`endif

  instr_alu u_alu (
    .opc      (instr_q.opc),
    .op_a     (instr_q.op_a),
    .op_b     (instr_q.op_b),
    .result   (alu_result),
    .div_zero (alu_div_zero)
  );

  always_comb begin
    state_d        = state_q;
    read_pointer_d = read_pointer_q;
    last_addr_d    = last_addr_q;
    instr_d        = instr_q;
    out_opcode_d   = out_opcode_q;
    out_addr_d     = out_addr_q;
    out_result_d   = out_result_q;
    div_zero_d     = div_zero_q;
`ifdef INSTR_READER_CHECK_EN
    check_err_d    = check_err_q;
    err_count_d    = err_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          read_pointer_d = first_addr;
          last_addr_d    = last_addr;
          state_d        = FETCH;
`ifdef INSTR_READER_CHECK_EN
          err_count_d    = '0;
`endif
        end
      end
      FETCH: begin
        instr_d = instruction_word;
        state_d = EXEC;
      end
      EXEC: begin
        out_result_d = alu_result;
        div_zero_d   = alu_div_zero;
        out_opcode_d = instr_q.opc;
        out_addr_d   = read_pointer_q;
        state_d      = OUT;
`ifdef INSTR_READER_CHECK_EN
        check_err_d  = (alu_result != instr_q.rezultat);
        if ((alu_result != instr_q.rezultat) && (err_count_q != 6'd63))
          err_count_d = err_count_q + 6'd1;
`endif
      end
      OUT: begin
        if (out_ready) begin
          if (read_pointer_q == last_addr_q) begin
            state_d = DONE;
          end else begin
            // 5-bit increment wraps 31 -> 0 for ranges crossing the top
            read_pointer_d = read_pointer_q + address_t'(1);
            state_d        = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      read_pointer_q <= '0;
      last_addr_q    <= '0;
      instr_q        <= '0;
      out_opcode_q   <= ZERO;
      out_addr_q     <= '0;
      out_result_q   <= '0;
      div_zero_q     <= 1'b0;
`ifdef INSTR_READER_CHECK_EN
      check_err_q    <= 1'b0;
      err_count_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      read_pointer_q <= read_pointer_d;
      last_addr_q    <= last_addr_d;
      instr_q        <= instr_d;
      out_opcode_q   <= out_opcode_d;
      out_addr_q     <= out_addr_d;
      out_result_q   <= out_result_d;
      div_zero_q     <= div_zero_d;
`ifdef INSTR_READER_CHECK_EN
      check_err_q    <= check_err_d;
      err_count_q    <= err_count_d;
`endif
    end
  end

  assign read_pointer = read_pointer_q;
  assign out_opcode   = out_opcode_q;
  assign out_addr     = out_addr_q;
  assign out_result   = out_result_q;
  assign div_zero     = div_zero_q;
  assign out_valid    = (state_q == OUT);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
`ifdef INSTR_READER_CHECK_EN
  assign check_err    = check_err_q;
  assign err_count    = err_count_q;
`endif

endmodule
